id_hazard_stage: RTL and testbench
==================================

// Module: id_hazard_stage
// PURPOSE
//  Parametrised decode-stage successor: holds one instruction in a registered ID slot with valid/ready
//  handshakes, forwards operands from FWD_SRC later stages, stalls on load-use hazards for LOAD_LAT
//  cycles and resolves branches/jumps in ID, issuing a registered one-cycle redirect. Sits between
//  fetch and the control_unit/EX register; register_file read data enters via rf_rdata1/rf_rdata2.
// PARAMETERS
//  DATA_W    32  datapath/PC width (>=32); PC arithmetic modulo 2^DATA_W
//  REG_AW    5   register address width; register 0 hard-wired zero
//  FWD_SRC   2   number of forwarding sources; index 0 = youngest, highest priority
//  LOAD_LAT  1   stall cycles inserted per load-use hazard (>=1)
// PORTS
//  clk             in   1                clock
//  rst             in   1                synchronous reset, active-low
//  in_valid        in   1                fetch offers instruction
//  in_ready        out  1                ID slot can accept
//  in_instr        in   32               instruction word
//  in_pc           in   DATA_W           PC of in_instr
//  br_op           in   3                decoded branch op for held instr: 0 none,1 EQ,2 NE,3 LEZ,4 GTZ,5 J,6 JR
//  rs_addr/rt_addr out  REG_AW           held instr[25:21]/[20:16], drive register_file reads
//  rf_rdata1/2     in   DATA_W           register_file read data for rs/rt (same cycle)
//  fwd_valid       in   FWD_SRC          source i writes a register
//  fwd_is_load     in   FWD_SRC          source i is a load (data not yet available)
//  fwd_addr        in   FWD_SRC*REG_AW   destination of source i
//  fwd_data        in   FWD_SRC*DATA_W   result of source i
//  out_valid       out  1                decoded instruction + operands valid
//  out_ready       in   1                EX accepts
//  out_instr/out_pc out 32/DATA_W        held instruction and PC
//  out_rs_val/out_rt_val out DATA_W      forwarded operands
//  redirect_valid  out  1                one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc     out  DATA_W           branch/jump target
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state EMPTY, slot invalid, stall counter 0; in_ready=0 during reset;
//   out_valid=0, redirect_valid=0, redirect_pc=0, out_instr=0, out_pc=0.
//  FSM: EMPTY -> HOLD on in_fire(in_valid&in_ready). HOLD: hazard -> STALL(cnt=LOAD_LAT);
//   else out_valid=1; out_fire & in_fire -> HOLD (new instr); out_fire only -> EMPTY.
//   STALL: cnt decrements each cycle, out_valid=0, in_ready=0; cnt==1 -> HOLD (re-evaluate).
//  Hazard: for rs/rt !=0, first (lowest index) matching fwd_valid source has fwd_is_load=1.
//  Forwarding: operand = fwd_data of lowest-index matching valid non-load source, else rf_rdata;
//   address 0 always yields 0. Combinational from held slot; no added latency.
//  in_ready = (EMPTY) | (HOLD & out_ready & !hazard & !taken); never accepts in STALL.
//  Branch taken (evaluated on forwarded values, signed): EQ rs==rt; NE rs!=rt; LEZ rs<=0; GTZ rs>0;
//   J, JR always. Targets: cond = pc+4+(sext(imm16)<<2); J = {(pc+4)[DATA_W-1:28],imm26,2'b00};
//   JR = rs value. No delay slot.
//  On out_fire with taken: redirect_valid=1 and redirect_pc registered, visible next cycle for exactly
//   one cycle; in_ready=0 in fire cycle so no wrong-path instruction enters; state -> EMPTY.
//  out_ready=0 in HOLD: slot and outputs stable (valid must not drop once raised unless reset).
//  Forward source change during HOLD re-evaluates hazard each cycle; a hazard arising while out_valid=1
//   and !out_ready drops to STALL (permitted only because EX not yet accepted).
//  Reset mid-STALL or mid-redirect: cleared next edge, no pulse emitted.
// CONFIGURATION
//  ID_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (cycles in STALL) and
//   perf_redirect_cnt[31:0] (redirect pulses); both saturate at 32'hFFFF_FFFF, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: rst=0 2 cycles with in_valid=1 -> in_ready=0,out_valid=0,redirect_valid=0 throughout.
//  2 Forward: rs=3, fwd0{3,data 0x11,non-load}, fwd1{3,0x22}, rf=0x33 -> out_rs_val=0x11; rs=0 -> 0.
//  3 Load-use LOAD_LAT=2: rt=5, fwd0 load to 5 -> out_valid=0, in_ready=0 exactly 2 cycles, then 1
//    with forwarded/rf value once fwd_is_load clears.
//  4 BEQ pc=0x100, imm16=0xFFFE, rs==rt=7, out_ready=1 -> next cycle redirect_valid=1, pc=0x0FC, 1 cycle.
//  5 J pc=0xF000_0000, imm26=0x0000040 -> redirect_pc=0xF000_0100; JR rs=0x2000 -> 0x2000.
//  6 Backpressure: out_ready=0 5 cycles -> out_* stable, in_ready=0; ID_PERF_CNT_EN counts checked.

Source files
------------

// File: rtl/id_hazard_stage.sv
// Decode-stage holding slot: operand forwarding, load-use stalls and in-ID branch/jump resolution.
// Optional ID_PERF_CNT_EN adds saturating stall-cycle and redirect-pulse counters.
`timescale 1ns/1ps
module id_hazard_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int FWD_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    input  logic [DATA_W-1:0]           in_pc,
    input  logic [2:0]                  br_op,
    output logic [REG_AW-1:0]           rs_addr,
    output logic [REG_AW-1:0]           rt_addr,
    input  logic [DATA_W-1:0]           rf_rdata1,
    input  logic [DATA_W-1:0]           rf_rdata2,
    input  logic [FWD_SRC-1:0]          fwd_valid,
    input  logic [FWD_SRC-1:0]          fwd_is_load,
    input  logic [FWD_SRC*REG_AW-1:0]   fwd_addr,
    input  logic [FWD_SRC*DATA_W-1:0]   fwd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [DATA_W-1:0]           out_pc,
    output logic [DATA_W-1:0]           out_rs_val,
    output logic [DATA_W-1:0]           out_rt_val,
    output logic                        redirect_valid,
    output logic [DATA_W-1:0]           redirect_pc
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_redirect_cnt
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_STALL} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               instr_q, instr_d;
    logic [DATA_W-1:0]         pc_q, pc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      redir_q, redir_d;
    logic [DATA_W-1:0]         rpc_q, rpc_d;

    logic signed [DATA_W-1:0]  rs_val, rt_val;
    logic                      rs_haz, rt_haz;
    logic                      hold, hazard, taken, out_fire, in_fire;
    logic [DATA_W-1:0]         pc4, imm_ext, target;

    // Lowest-index matching writer wins; a load there means the value is not ready yet.
    function automatic void fwd_lookup(
        input  logic [REG_AW-1:0]         addr,
        input  logic [DATA_W-1:0]         rf_val,
        input  logic [FWD_SRC-1:0]        vld,
        input  logic [FWD_SRC-1:0]        is_load,
        input  logic [FWD_SRC*REG_AW-1:0] dst,
        input  logic [FWD_SRC*DATA_W-1:0] data,
        output logic [DATA_W-1:0]         val,
        output logic                      haz
    );
        logic found;
        found = 1'b0;
        val   = rf_val;
        haz   = 1'b0;
        for (int i = 0; i < FWD_SRC; i++) begin
            if (!found && vld[i] && (dst[i*REG_AW +: REG_AW] == addr)) begin
                found = 1'b1;
                haz   = is_load[i];
                if (!is_load[i]) val = data[i*DATA_W +: DATA_W];
            end
        end
        if (addr == '0) begin
            val = '0;
            haz = 1'b0;
        end
    endfunction

    assign rs_addr = REG_AW'(instr_q[25:21]);
    assign rt_addr = REG_AW'(instr_q[20:16]);

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        fwd_lookup(rs_addr, rf_rdata1, fwd_valid, fwd_is_load, fwd_addr, fwd_data, rs_val, rs_haz);
        fwd_lookup(rt_addr, rf_rdata2, fwd_valid, fwd_is_load, fwd_addr, fwd_data, rt_val, rt_haz);

        hold   = (state_q == S_HOLD);
        hazard = hold && (rs_haz || rt_haz);

        pc4     = pc_q + DATA_W'(4);
        imm_ext = {{(DATA_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
        target  = pc4 + imm_ext;
        case (br_op)
            3'd1:    taken = (rs_val == rt_val);
            3'd2:    taken = (rs_val != rt_val);
            3'd3:    taken = rs_val[DATA_W-1] || (rs_val == '0);
            3'd4:    taken = !rs_val[DATA_W-1] && (rs_val != '0);
            3'd5: begin
                taken  = 1'b1;
                target = {pc4[DATA_W-1:28], instr_q[25:0], 2'b00};
            end
            3'd6: begin
                taken  = 1'b1;
                target = rs_val;
            end
            default: taken = 1'b0;
        endcase

        out_valid = rst && hold && !hazard;
        out_fire  = out_valid && out_ready;
        // Taken control transfer blocks intake so no wrong-path instruction slips in.
        in_ready  = rst && ((state_q == S_EMPTY) || (hold && out_ready && !hazard && !taken));
        in_fire   = in_valid && in_ready;

        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        redir_d = 1'b0;
        rpc_d   = rpc_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d = S_HOLD;
                    instr_d = in_instr;
                    pc_d    = in_pc;
                end
            end
            S_HOLD: begin
                if (hazard) begin
                    state_d = S_STALL;
                    cnt_d   = CNT_W'(LOAD_LAT);
                end else if (out_fire) begin
                    if (taken) begin
                        state_d = S_EMPTY;
                        redir_d = 1'b1;
                        rpc_d   = target;
                    end else if (in_fire) begin
                        instr_d = in_instr;
                        pc_d    = in_pc;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            S_STALL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_HOLD;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            redir_q <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            redir_q <= redir_d;
            rpc_q   <= rpc_d;
        end
    end

    assign out_instr      = instr_q;
    assign out_pc         = pc_q;
    assign out_rs_val     = rs_val;
    assign out_rt_val     = rt_val;
    assign redirect_valid = redir_q && rst;
    assign redirect_pc    = rpc_q;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if ((state_q == S_STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (redir_d && (redir_cnt_q != 32'hFFFF_FFFF))              redir_cnt_d = redir_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_stage.sv
// Scoreboard bench for id_hazard_stage (LOAD_LAT=2); also checks perf counters when ID_PERF_CNT_EN is set.
`timescale 1ns/1ps
module tb_id_hazard_stage;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int FWD_SRC  = 2;
    localparam int LOAD_LAT = 2;

    logic                      clk, rst;
    logic                      in_valid, in_ready;
    logic [31:0]               in_instr;
    logic [DATA_W-1:0]         in_pc;
    logic [2:0]                br_op;
    logic [REG_AW-1:0]         rs_addr, rt_addr;
    logic [DATA_W-1:0]         rf_rdata1, rf_rdata2;
    logic [FWD_SRC-1:0]        fwd_valid, fwd_is_load;
    logic [FWD_SRC*REG_AW-1:0] fwd_addr;
    logic [FWD_SRC*DATA_W-1:0] fwd_data;
    logic                      out_valid, out_ready;
    logic [31:0]               out_instr;
    logic [DATA_W-1:0]         out_pc, out_rs_val, out_rt_val;
    logic                      redirect_valid;
    logic [DATA_W-1:0]         redirect_pc;
`ifdef ID_PERF_CNT_EN
    logic [31:0]               perf_stall_cnt, perf_redirect_cnt;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] tgt;
        logic        taken;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;
    int          exp_redir = 0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rpc = '0;
    logic [31:0] regs [32];

    id_hazard_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_SRC(FWD_SRC), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .br_op(br_op), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
`ifdef ID_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rdata1 = regs[rs_addr];
    assign rf_rdata2 = regs[rt_addr];

    // Decoder model for the held instruction.
    always_comb begin
        br_op = 3'd0;
        case (out_instr[31:26])
            6'h04: br_op = 3'd1;
            6'h05: br_op = 3'd2;
            6'h06: br_op = 3'd3;
            6'h07: br_op = 3'd4;
            6'h02: br_op = 3'd5;
            6'h00: if (out_instr[5:0] == 6'h08) br_op = 3'd6;
            default: br_op = 3'd0;
        endcase
    end

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, 5'd0, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < FWD_SRC; i++)
            if (fwd_valid[i] && fwd_addr[i*REG_AW +: REG_AW] == a)
                return fwd_is_load[i] ? 32'hxxxx_xxxx : fwd_data[i*DATA_W +: DATA_W];
        return regs[a];
    endfunction

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] pc4;
        e.instr = instr;
        e.pc    = pc;
        e.rs    = opnd(instr[25:21]);
        e.rt    = opnd(instr[20:16]);
        pc4     = pc + 32'd4;
        e.taken = 1'b0;
        e.tgt   = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
        case (instr[31:26])
            6'h04: e.taken = (e.rs == e.rt);
            6'h05: e.taken = (e.rs != e.rt);
            6'h06: e.taken = ($signed(e.rs) <= 0);
            6'h07: e.taken = ($signed(e.rs) > 0);
            6'h02: begin
                e.taken = 1'b1;
                e.tgt   = {pc4[31:28], instr[25:0], 2'b00};
            end
            6'h00: if (instr[5:0] == 6'h08) begin
                e.taken = 1'b1;
                e.tgt   = e.rs;
            end
            default: e.taken = 1'b0;
        endcase
        return e;
    endfunction

    task automatic set_fwd(input int i, input logic v, input logic ld, input logic [4:0] a, input logic [31:0] d);
        fwd_valid[i]                  = v;
        fwd_is_load[i]                = ld;
        fwd_addr[i*REG_AW +: REG_AW]  = a;
        fwd_data[i*DATA_W +: DATA_W]  = d;
    endtask

    // Offer one instruction, push its expectation once it is accepted.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL send_accept instr=%h got in_ready=%b required=1", instr, in_ready);
        end else begin
            e = mk(instr, pc);
            sb.push_back(e);
            if (e.taken) exp_redir++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard consumer and redirect-pulse checker.
    always @(negedge clk) begin
        exp_t e;
        logic fire_taken;
        logic [31:0] fire_tgt;
        fire_taken = 1'b0;
        fire_tgt   = '0;
        checks++;
        if (redirect_valid !== (exp_rv & rst)) begin
            failures++;
            $display("FAIL redirect_valid got=%b required=%b", redirect_valid, exp_rv & rst);
        end
        if (exp_rv && rst) begin
            checks++;
            if (redirect_pc !== exp_rpc) begin
                failures++;
                $display("FAIL redirect_pc got=%h required=%h", redirect_pc, exp_rpc);
            end
        end
        if (rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected out_instr=%h with empty scoreboard", out_instr);
            end else begin
                e = sb.pop_front();
                if (out_instr !== e.instr || out_pc !== e.pc) begin
                    failures++;
                    $display("FAIL sb_instr got=%h/%h required=%h/%h", out_instr, out_pc, e.instr, e.pc);
                end
                checks++;
                if (out_rs_val !== e.rs) begin
                    failures++;
                    $display("FAIL sb_rs instr=%h got=%h required=%h", e.instr, out_rs_val, e.rs);
                end
                checks++;
                if (out_rt_val !== e.rt) begin
                    failures++;
                    $display("FAIL sb_rt instr=%h got=%h required=%h", e.instr, out_rt_val, e.rt);
                end
                fire_taken = e.taken;
                fire_tgt   = e.tgt;
            end
        end
        exp_rv  = fire_taken & rst;
        exp_rpc = fire_tgt;
    end

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h1234_5678;
        in_pc    = 32'h40;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctrl got in_ready=%b out_valid=%b redirect=%b required 0/0/0",
                         in_ready, out_valid, redirect_valid);
            end
            checks++;
            if (out_instr !== 32'd0 || out_pc !== 32'd0 || redirect_pc !== 32'd0) begin
                failures++;
                $display("FAIL reset_data got instr=%h pc=%h rpc=%h required 0", out_instr, out_pc, redirect_pc);
            end
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
`ifdef ID_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_perf got %0d/%0d required 0/0", perf_stall_cnt, perf_redirect_cnt);
        end
`endif
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        regs[3]   = 32'h33;
        set_fwd(0, 1'b1, 1'b0, 5'd3, 32'h11);
        set_fwd(1, 1'b1, 1'b0, 5'd3, 32'h22);
        send(r_type(5'd3, 5'd0), 32'h1000);
        send(r_type(5'd0, 5'd3), 32'h1004);
        drain();
        set_fwd(0, 1'b1, 1'b0, 5'd8, 32'h11);
        send(r_type(5'd3, 5'd3), 32'h1008);
        drain();
        set_fwd(1, 1'b0, 1'b0, 5'd3, 32'h22);
        send(r_type(5'd3, 5'd0), 32'h100C);
        drain();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL forward_drain got pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        int   n;
        out_ready = 1'b1;
        regs[5]   = 32'h55;
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'hBAD0);
        set_fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
        send(r_type(5'd0, 5'd5), 32'h2000);
        e = sb.pop_back();
        e.rt = 32'h5A5A;
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_detect got out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h5A5A);
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 10) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL loaduse_in_ready got=%b required=0", in_ready);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== LOAD_LAT) begin
            failures++;
            $display("FAIL loaduse_len got=%0d required=%0d", n, LOAD_LAT);
        end
        exp_stall += LOAD_LAT;
        drain();
        set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        regs[1]   = 32'd7;
        regs[2]   = 32'd7;
        regs[10]  = 32'hFFFF_FFF0;
        send({6'h04, 5'd1, 5'd2, 16'hFFFE}, 32'h100);
        in_valid = 1'b1;
        in_instr = 32'hDEAD_BEEF;
        in_pc    = 32'h104;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL branch_wrongpath got in_ready=%b required=0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        send({6'h05, 5'd1, 5'd2, 16'h0010}, 32'h200);
        send({6'h06, 5'd10, 5'd0, 16'h0004}, 32'h300);
        drain();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL branch_drain got pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_jump();
        out_ready = 1'b1;
        regs[9]   = 32'h2000;
        send({6'h02, 26'h000_0040}, 32'hF000_0000);
        drain();
        send({6'h00, 5'd9, 5'd0, 5'd0, 5'd0, 6'h08}, 32'h500);
        drain();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL jump_drain got pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [31:0] i1, i2;
        i1 = r_type(5'd4, 5'd0);
        i2 = r_type(5'd0, 5'd4);
        regs[4]   = 32'h44;
        out_ready = 1'b0;
        send(i1, 32'h400);
        in_valid = 1'b1;
        in_instr = i2;
        in_pc    = 32'h404;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_instr !== i1 || out_pc !== 32'h400 || out_rs_val !== 32'h44) begin
                failures++;
                $display("FAIL bp_stable got v=%b instr=%h pc=%h rs=%h required 1/%h/400/44",
                         out_valid, out_instr, out_pc, out_rs_val, i1);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready got=%b required=0", in_ready);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready got=%b required=1", in_ready);
        end else begin
            sb.push_back(mk(i2, 32'h404));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL bp_drain got pending=%0d required=0", sb.size());
        end
`ifdef ID_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt !== exp_stall || perf_redirect_cnt !== exp_redir) begin
            failures++;
            $display("FAIL perf_counts got %0d/%0d required %0d/%0d",
                     perf_stall_cnt, perf_redirect_cnt, exp_stall, exp_redir);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b1;
        regs[6]   = 32'h66;
        set_fwd(0, 1'b1, 1'b1, 5'd6, 32'h0);
        send(r_type(5'd6, 5'd0), 32'h600);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_hold got out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'd0) begin
            failures++;
            $display("FAIL midrst_clear got out_valid=%b in_ready=%b instr=%h required 0/1/0",
                     out_valid, in_ready, out_instr);
        end
`ifdef ID_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midrst_perf got=%0d required=0", perf_stall_cnt);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        out_ready   = 1'b0;
        fwd_valid   = '0;
        fwd_is_load = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_jump();
        test_back_to_back_backpressure();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
